glitc_settings_update_scheduler: RTL and testbench

//  Parametrised shadow-register bank for external GLITC settings: NUM_DAC Vped DACs and NUM_ATT attenuators.

---
 rtl/glitc_settings_update_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_glitc_settings_update_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitc_settings_update_scheduler.sv
// glitc_settings_update_scheduler: shadow-register bank for GLITC Vped DACs and attenuators, drained round-robin to the I2C engine.
//  Ports: user_clk_i/user_rst_i clock and sync active-high reset; user_sel_i/user_wr_i/user_addr_i/user_dat_i/user_dat_o
//  register bus (read combinational); upd_req_o/upd_chan_o/upd_dat_o/upd_eeprom_o request to the I2C engine,
//  upd_ack_i/upd_err_i its completion; busy_o high while a channel is being serviced.
//  Optional SETTINGS_ERROR_FIFO_EN: ERR_DEPTH-entry error FIFO instead of a single error register.
module glitc_settings_update_scheduler #(
  parameter int NUM_DAC   = 8,
  parameter int DAC_BITS  = 12,
  parameter int NUM_ATT   = 6,
  parameter int ATT_BITS  = 6,
  parameter int MAX_RETRY = 3,
  parameter int ERR_DEPTH = 8
) (
  input  logic        user_clk_i,
  input  logic        user_rst_i,
  input  logic        user_sel_i,
  input  logic        user_wr_i,
  input  logic [4:0]  user_addr_i,
  input  logic [31:0] user_dat_i,
  output logic [31:0] user_dat_o,
  output logic        upd_req_o,
  output logic [4:0]  upd_chan_o,
  output logic [15:0] upd_dat_o,
  output logic        upd_eeprom_o,
  input  logic        upd_ack_i,
  input  logic        upd_err_i,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DONE} state_t;
  localparam logic [4:0]  ND       = 5'(NUM_DAC);
  localparam logic [4:0]  NA       = 5'(NUM_ATT);
  localparam logic [15:0] DAC_MASK = 16'((1 << DAC_BITS) - 1);
  localparam logic [15:0] ATT_MASK = 16'((1 << ATT_BITS) - 1);
  localparam logic [7:0]  MR       = 8'(MAX_RETRY);
  state_t state;
  // Channel index doubles as bit index of pending and as the register address.
  logic [15:0] dac_q [16];
  logic [15:0] att_q [16];
  logic [31:0] pending, set_vec, clr_vec;
  logic [4:0]  last_ch, cur_ch, sel_ch, inflight, err_head;
  logic [7:0]  retry;
  logic        dirty, err_q, pause, overflow, push, pop, ovf_set, err_pend, final_try;
  logic        dac_hit, att_hit, wr, wr_dac, wr_att, wr_ctl, wr_chan;
  logic        unused_ok;
  assign dac_hit   = ~user_addr_i[4] & ({1'b0, user_addr_i[3:0]} < ND);
  assign att_hit   = user_addr_i[4] & ({1'b0, user_addr_i[3:0]} < NA);
  assign wr        = user_sel_i & user_wr_i;
  assign wr_dac    = wr & dac_hit;
  assign wr_att    = wr & att_hit;
  assign wr_ctl    = wr & (user_addr_i == 5'h1E);
  assign wr_chan   = wr_dac | wr_att;
  assign pop       = wr_ctl & user_dat_i[8];
  assign final_try = (retry + 8'd1) >= MR;
  assign push      = (state == DONE) & err_q & final_try;
  assign inflight  = (state == SCAN) ? sel_ch : cur_ch;
  assign set_vec   = wr_chan ? 32'd1 << user_addr_i : 32'd0;
  // A write landing while the channel is in flight keeps its pending bit alive.
  assign clr_vec   = ((state == DONE) & (~err_q | final_try) & ~dirty) ? 32'd1 << cur_ch : 32'd0;
  assign upd_chan_o = cur_ch;
  // Lowest pending channel strictly above last_ch, wrapping; j=32 lands back on last_ch itself.
  always_comb begin
    sel_ch = last_ch;
    for (int j = 32; j >= 1; j--)
      if (pending[last_ch + 5'(j)]) sel_ch = last_ch + 5'(j);
  end
  always_comb begin
    user_dat_o = dac_hit ? {16'd0, dac_q[user_addr_i[3:0]]}
               : att_hit ? {16'd0, att_q[user_addr_i[3:0]]}
               : (user_addr_i == 5'h1E) ? {|pending, pause, 13'd0, busy_o, 6'd0, overflow, err_pend, 3'd0, err_head}
               : (user_addr_i == 5'h1F) ? pending : 32'd0;
  end
  always_ff @(posedge user_clk_i) begin
    if (user_rst_i) begin
      for (int i = 0; i < 16; i++) begin
        dac_q[i] <= '0;
        att_q[i] <= '0;
      end
      pending  <= '0;
      pause    <= 1'b0;
      overflow <= 1'b0;
      dirty    <= 1'b0;
    end else begin
      if (wr_dac) dac_q[user_addr_i[3:0]] <= user_dat_i[15:0] & (DAC_MASK | 16'h8000);
      if (wr_att) att_q[user_addr_i[3:0]] <= user_dat_i[15:0] & ATT_MASK;
      if (wr_ctl) pause <= user_dat_i[30];
      pending  <= (pending & ~clr_vec) | set_vec;
      overflow <= ovf_set | (overflow & ~(wr_ctl & user_dat_i[9]));
      dirty    <= (wr_chan & (state != IDLE) & (user_addr_i == inflight)) | (dirty & (state != SCAN));
    end
  end
  always_ff @(posedge user_clk_i) begin
    if (user_rst_i) begin
      state        <= IDLE;
      upd_req_o    <= 1'b0;
      busy_o       <= 1'b0;
      cur_ch       <= '0;
      last_ch      <= '0;
      upd_dat_o    <= '0;
      upd_eeprom_o <= 1'b0;
      retry        <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|pending & ~pause) begin
          state  <= SCAN;
          busy_o <= 1'b1;
        end
        SCAN: begin
          cur_ch       <= sel_ch;
          last_ch      <= sel_ch;
          upd_dat_o    <= sel_ch[4] ? att_q[sel_ch[3:0]] : dac_q[sel_ch[3:0]] & DAC_MASK;
          upd_eeprom_o <= ~sel_ch[4] & dac_q[sel_ch[3:0]][15];
          upd_req_o    <= 1'b1;
          state        <= ISSUE;
        end
        ISSUE: if (upd_ack_i) begin
          upd_req_o <= 1'b0;
          err_q     <= upd_err_i;
          state     <= DONE;
        end
        DONE: if (err_q & ~final_try) begin
          retry     <= retry + 8'd1;
          upd_req_o <= 1'b1;
          state     <= ISSUE;
        end else begin
          retry  <= '0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SETTINGS_ERROR_FIFO_EN
  localparam int AW = $clog2(ERR_DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(ERR_DEPTH);
  logic [4:0]    err_mem [ERR_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          do_pop, do_push;
  assign do_pop    = pop & (cnt != '0);
  // A pop in the same cycle frees the slot the push needs.
  assign do_push   = push & ((cnt != FULL) | do_pop);
  assign ovf_set   = push & ~do_push;
  assign err_pend  = cnt != '0;
  assign err_head  = err_pend ? err_mem[rp] : '0;
  assign unused_ok = ^{user_dat_i[31], user_dat_i[29:16]};
  always_ff @(posedge user_clk_i)
    if (do_push) err_mem[wp] <= cur_ch;
  always_ff @(posedge user_clk_i) begin
    if (user_rst_i) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end
`else
  logic       err_v;
  logic [4:0] err_c;
  assign ovf_set   = push & err_v & ~pop;
  assign err_pend  = err_v;
  assign err_head  = err_v ? err_c : '0;
  assign unused_ok = ^{user_dat_i[31], user_dat_i[29:16], ERR_DEPTH[0]};
  always_ff @(posedge user_clk_i) begin
    if (user_rst_i) begin
      err_v <= 1'b0;
      err_c <= '0;
    end else if (push) begin
      err_v <= 1'b1;
      err_c <= cur_ch;
    end else if (pop) begin
      err_v <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_glitc_settings_update_scheduler.sv
// tb_glitc_settings_update_scheduler: randomized bench for the settings update scheduler against a behavioural model.
module tb_glitc_settings_update_scheduler;
  localparam int NUM_DAC = 8, DAC_BITS = 12, NUM_ATT = 6, ATT_BITS = 6, MAX_RETRY = 3;
`ifdef SETTINGS_ERROR_FIFO_EN
  localparam int CAP = 8;
`else
  localparam int CAP = 1;
`endif
  logic clk = 1'b0, rst, sel, wr, req, ack, err, busy, ee;
  logic [4:0] addr, chan;
  logic [31:0] din, dout;
  logic [15:0] dat;
  int total = 0, bad = 0;
  int m_dac [16], m_att [16], m_last, errq [$];
  bit m_ee [16], m_ovf, m_pause;
  bit [31:0] m_pend;

  glitc_settings_update_scheduler dut (
    .user_clk_i(clk), .user_rst_i(rst), .user_sel_i(sel), .user_wr_i(wr),
    .user_addr_i(addr), .user_dat_i(din), .user_dat_o(dout),
    .upd_req_o(req), .upd_chan_o(chan), .upd_dat_o(dat), .upd_eeprom_o(ee),
    .upd_ack_i(ack), .upd_err_i(err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic int ch_of(int i);
    return i < NUM_DAC ? i : 16 + i - NUM_DAC;
  endfunction

  function automatic int next_ch();
    for (int j = 1; j <= 32; j++) if (m_pend[(m_last + j) % 32]) return (m_last + j) % 32;
    return -1;
  endfunction

  function automatic logic [15:0] exp_dat(int c);
    return c < 16 ? 16'(m_dac[c]) : 16'(m_att[c - 16]);
  endfunction

  function automatic logic [31:0] exp_rd(int c);
    return c < 16 ? 32'(m_dac[c]) | (32'(m_ee[c]) << 15) : 32'(m_att[c - 16]);
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s = 0;
    s[7:0] = errq.size() > 0 ? 8'(errq[0]) : 8'd0;
    s[8] = errq.size() > 0;
    s[9] = m_ovf;
    s[30] = m_pause;
    s[31] = m_pend != 0;
    return s;
  endfunction

  function automatic void push_err(int c);
    if (errq.size() >= CAP) begin
      m_ovf = 1;
      if (CAP == 1) begin
        errq.delete();
        errq.push_back(c);
      end
    end else errq.push_back(c);
  endfunction

  task automatic do_reset();
    rst = 1; sel = 0; wr = 0; ack = 0; err = 0; addr = 0; din = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    m_pend = 0; m_last = 0; errq.delete(); m_ovf = 0; m_pause = 0;
    for (int i = 0; i < 16; i++) begin
      m_dac[i] = 0; m_att[i] = 0; m_ee[i] = 0;
    end
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    int k = int'(a);
    sel = 1; wr = 1; addr = a; din = d;
    @(posedge clk);
    #1 sel = 0; wr = 0;
    if (k < NUM_DAC) begin
      m_dac[k] = int'(d) & ((1 << DAC_BITS) - 1); m_ee[k] = d[15]; m_pend[k] = 1;
    end else if (k >= 16 && k < 16 + NUM_ATT) begin
      m_att[k - 16] = int'(d) & ((1 << ATT_BITS) - 1); m_pend[k] = 1;
    end else if (k == 30) begin
      m_pause = d[30];
      if (d[9]) m_ovf = 0;
      if (d[8] && errq.size() > 0) void'(errq.pop_front());
    end
  endtask

  task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
    addr = a;
    #1 v = dout;
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (req) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack_pulse(input bit e);
    ack = 1; err = e;
    @(posedge clk);
    #1 ack = 0; err = 0;
  endtask

  task automatic serve_one(input int errs);
    int c = next_ch();
    logic [15:0] d = exp_dat(c);
    bit e_ee = c < 16 && m_ee[c];
    bit ok;
    for (int a = 0; a < MAX_RETRY; a++) begin
      wait_req(ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL req_timeout got=0 exp=1 chan=%0d attempt=%0d", c, a);
        return;
      end
      total++;
      if ({chan, dat, ee} !== {5'(c), d, e_ee}) begin
        bad++;
        $display("FAIL req_fields got chan=%0d dat=%h ee=%b exp chan=%0d dat=%h ee=%b", chan, dat, ee, c, d, e_ee);
      end
      ack_pulse(a < errs);
      if (a >= errs) break;
    end
    m_last = c;
    m_pend[c] = 0;
    if (errs >= MAX_RETRY) push_err(c);
  endtask

  task automatic check_rd(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd_reg(a, v);
    total++;
    if (v !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, v, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({req, busy} !== 2'b00) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=00", {req, busy});
    end
    check_rd("reset_bitmap", 5'h1F, 32'd0);
    check_rd("reset_status", 5'h1E, 32'd0);
    check_rd("reset_dac0", 5'h00, 32'd0);
    wr_reg(5'(NUM_DAC), 32'hFFFF);
    wr_reg(5'h1D, 32'hFFFF);
    ack_pulse(0);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (req !== 1'b0) begin
      bad++;
      $display("FAIL unmapped_req got=%b exp=0", req);
    end
    check_rd("unmapped_rd", 5'(NUM_DAC), 32'd0);
    check_rd("unmapped_1d", 5'h1D, 32'd0);
    check_rd("unmapped_bitmap", 5'h1F, 32'd0);
  endtask

  task automatic test_latency();
    do_reset();
    wr_reg(5'h00, 32'h8ABC);
    check_rd("dac0_readback", 5'h00, 32'h8ABC);
    total++;
    if (req !== 1'b0) begin
      bad++;
      $display("FAIL latency_n got=%b exp=0", req);
    end
    @(posedge clk);
    #1;
    total++;
    if (req !== 1'b0) begin
      bad++;
      $display("FAIL latency_n1 got=%b exp=0", req);
    end
    @(posedge clk);
    #1;
    total++;
    if ({req, chan, dat, ee} !== {1'b1, 5'd0, 16'h0ABC, 1'b1}) begin
      bad++;
      $display("FAIL latency_n2 got req=%b chan=%0d dat=%h ee=%b exp req=1 chan=0 dat=0abc ee=1", req, chan, dat, ee);
    end
    ack_pulse(0);
    m_last = 0;
    m_pend[0] = 0;
    repeat (2) @(posedge clk);
    #1;
    check_rd("t1_bitmap", 5'h1F, 32'd0);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL t1_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_order();
    do_reset();
    wr_reg(5'd3, $urandom);
    wr_reg(5'd1, $urandom);
    wr_reg(5'd18, $urandom);
    repeat (3) serve_one(0);
    repeat (2) @(posedge clk);
    #1;
    check_rd("t2_bitmap", 5'h1F, 32'd0);
  endtask

  task automatic test_retry();
    int extra = 0;
    do_reset();
    wr_reg(5'd5, $urandom);
    serve_one(MAX_RETRY);
    repeat (6) begin
      if (req) extra++;
      @(posedge clk);
      #1;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL t3_extra_req got=%0d exp=0", extra);
    end
    check_rd("t3_status", 5'h1E, exp_status());
    check_rd("t3_bitmap", 5'h1F, 32'd0);
  endtask

  task automatic test_dirty();
    logic [31:0] v1 = $urandom, v2, bm;
    bit ok;
    v2 = v1 ^ 32'h5;
    do_reset();
    wr_reg(5'd2, v1);
    wait_req(ok);
    total++;
    if (!ok || dat !== exp_dat(2)) begin
      bad++;
      $display("FAIL t4_first got ok=%b dat=%h exp ok=1 dat=%h", ok, dat, exp_dat(2));
    end
    wr_reg(5'd2, v2);
    ack_pulse(0);
    m_last = 2;
    @(posedge clk);
    #1;
    rd_reg(5'h1F, bm);
    total++;
    if (bm[2] !== 1'b1) begin
      bad++;
      $display("FAIL t4_pending got=%b exp=1", bm[2]);
    end
    serve_one(0);
    repeat (2) @(posedge clk);
    #1;
    check_rd("t4_bitmap", 5'h1F, 32'd0);
  endtask

  task automatic test_pause();
    int seen = 0;
    bit got = 0;
    do_reset();
    wr_reg(5'h1E, 32'h4000_0000);
    wr_reg(5'h10, $urandom);
    repeat (5) begin
      @(posedge clk);
      #1;
      if (req) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL t5_paused_req got=%0d exp=0", seen);
    end
    check_rd("t5_status", 5'h1E, exp_status());
    wr_reg(5'h1E, 32'd0);
    for (int i = 0; i < 2 && !got; i++) begin
      @(posedge clk);
      #1;
      got = req;
    end
    total++;
    if (!got || chan !== 5'd16 || dat !== exp_dat(16)) begin
      bad++;
      $display("FAIL t5_resume got req=%b chan=%0d dat=%h exp req=1 chan=16 dat=%h", got, chan, dat, exp_dat(16));
    end
    ack_pulse(0);
    m_last = 16;
    m_pend[16] = 0;
  endtask

  task automatic test_errq();
    do_reset();
    for (int i = 0; i <= CAP; i++) begin
      wr_reg(5'(ch_of(i + 1)), $urandom);
      serve_one(MAX_RETRY);
    end
    repeat (3) @(posedge clk);
    #1;
    check_rd("errq_overflow", 5'h1E, exp_status());
    for (int i = 0; i < CAP; i++) wr_reg(5'h1E, 32'h100);
    check_rd("errq_drained", 5'h1E, exp_status());
    wr_reg(5'h1E, 32'h100);
    check_rd("errq_pop_empty", 5'h1E, exp_status());
    wr_reg(5'h1E, 32'h200);
    check_rd("errq_ovf_clear", 5'h1E, exp_status());
  endtask

  task automatic test_random();
    do_reset();
    for (int r = 0; r < 25; r++) begin
      int n = $urandom_range(1, 6), guard = 0, c = 0;
      wr_reg(5'h1E, 32'h4000_0000);
      for (int i = 0; i < n; i++) begin
        c = ch_of($urandom % (NUM_DAC + NUM_ATT));
        wr_reg(5'(c), $urandom);
      end
      check_rd("rand_readback", 5'(c), exp_rd(c));
      wr_reg(5'h1E, 32'd0);
      while (m_pend != 0 && guard < 40) begin
        serve_one($urandom_range(0, 3));
        guard++;
      end
      repeat (3) @(posedge clk);
      #1;
      check_rd("rand_status", 5'h1E, exp_status());
      check_rd("rand_bitmap", 5'h1F, 32'd0);
      if ($urandom % 2) wr_reg(5'h1E, 32'h300);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_order();
    test_retry();
    test_dirty();
    test_pause();
    test_errq();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
